// File: rtl/fifo_uart_tx_drain.sv
// Pops bytes from the sync FIFO and serialises them as UART frames; txd falls 3 cycles after en & ~empty.
// Backpressure: a FIFO write in the same cycle wins, so fifo_rd is held in FETCH until the pop is accepted.
module fifo_uart_tx_drain #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        fifo_empty,
    input  logic        fifo_full,
    input  logic        fifo_wr,
    input  logic [7:0]  fifo_dout,
    output logic        fifo_rd,
    output logic        txd,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic        PEN       = (PARITY_EN != 0);
    localparam logic        ODD       = (PARITY_ODD != 0);

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        txd_q, txd_d;
    logic [15:0] cnt_q, cnt_d;
    logic        accept;
    logic        bit_end;
    logic        timed;

    // A same-cycle write that the FIFO accepts blocks our read.
    assign accept  = fifo_rd & ~fifo_empty & ~(fifo_wr & ~fifo_full);
    assign bit_end = (baud_q == BAUD_LAST);
    assign timed   = (state_q == S_START) || (state_q == S_DATA) ||
                     (state_q == S_PARITY) || (state_q == S_STOP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (en && !fifo_empty) state_d = S_FETCH;
            S_FETCH: begin
                if (accept)          state_d = S_LOAD;
                else if (fifo_empty) state_d = S_IDLE;
            end
            S_LOAD:   state_d = S_START;
            S_START:  if (bit_end) state_d = S_DATA;
            S_DATA:   if (bit_end && bit_q == 3'd7) state_d = PEN ? S_PARITY : S_STOP;
            S_PARITY: if (bit_end) state_d = S_STOP;
            S_STOP:   if (bit_end) state_d = (en && !fifo_empty) ? S_FETCH : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // txd is registered: each value is loaded on the last cycle of the previous bit.
    always_comb begin
        baud_d  = '0;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        txd_d   = txd_q;
        cnt_d   = cnt_q;
        if (timed && !bit_end) baud_d = baud_q + 16'd1;
        case (state_q)
            S_IDLE, S_FETCH: txd_d = 1'b1;
            S_LOAD: begin
                shift_d = fifo_dout;
                par_d   = (^fifo_dout) ^ ODD;
                bit_d   = '0;
                txd_d   = 1'b0;
            end
            S_START:  if (bit_end) txd_d = shift_q[0];
            S_DATA: begin
                if (bit_end) begin
                    bit_d   = bit_q + 3'd1;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) txd_d = PEN ? par_q : 1'b1;
                    else               txd_d = shift_q[1];
                end
            end
            S_PARITY: if (bit_end) txd_d = 1'b1;
            S_STOP: begin
                txd_d = 1'b1;
                if (bit_end) cnt_d = cnt_q + 16'd1;
            end
            default: txd_d = 1'b1;
        endcase
    end

    always_comb begin
        fifo_rd    = (state_q == S_FETCH);
        busy       = (state_q != S_IDLE);
        frame_done = (state_q == S_STOP) && bit_end;
        txd        = txd_q;
        frame_cnt  = cnt_q;
    end

endmodule

// File: tb/tb_fifo_uart_tx_drain.sv
// Three drain instances (plain, even parity, odd parity at a different bit time) fed by
// behavioural FIFO models; a per-instance monitor decodes every frame against the byte queue.
module tb_fifo_uart_tx_drain;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        fifo_wr = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [2:0]  fifo_empty = 3'b111;
    logic [2:0]  fifo_full = 3'b000;
    logic [2:0]  fifo_rd, txd, busy, frame_done;
    logic [7:0]  fifo_dout [3];
    logic [15:0] frame_cnt [3];

    logic [7:0]  fq    [3][$];
    logic [7:0]  exp_q [3][$];
    logic [15:0] cnt_m [3] = '{default: 16'd0};
    int          last_end [3] = '{default: -1};
    int          lat [3];
    int          run [3];
    int          cyc = 0;
    bit          gap_chk = 1'b0;
    logic [2:0]  seen;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fifo_uart_tx_drain #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty[0]), .fifo_full(fifo_full[0]),
        .fifo_wr(fifo_wr), .fifo_dout(fifo_dout[0]), .fifo_rd(fifo_rd[0]), .txd(txd[0]),
        .busy(busy[0]), .frame_done(frame_done[0]), .frame_cnt(frame_cnt[0]));
    fifo_uart_tx_drain #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty[1]), .fifo_full(fifo_full[1]),
        .fifo_wr(fifo_wr), .fifo_dout(fifo_dout[1]), .fifo_rd(fifo_rd[1]), .txd(txd[1]),
        .busy(busy[1]), .frame_done(frame_done[1]), .frame_cnt(frame_cnt[1]));
    fifo_uart_tx_drain #(.CLKS_PER_BIT(5), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty[2]), .fifo_full(fifo_full[2]),
        .fifo_wr(fifo_wr), .fifo_dout(fifo_dout[2]), .fifo_rd(fifo_rd[2]), .txd(txd[2]),
        .busy(busy[2]), .frame_done(frame_done[2]), .frame_cnt(frame_cnt[2]));

    function automatic int cpb(input int k);
        return (k == 2) ? 5 : 4;
    endfunction
    function automatic bit pen(input int k);
        return (k != 0);
    endfunction
    function automatic bit podd(input int k);
        return (k == 2);
    endfunction

    // 16-deep FIFO: a write that fits wins over a read in the same cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                fq[k].delete();
                fifo_dout[k] <= 8'h00;
            end
            fifo_empty <= 3'b111;
            fifo_full  <= 3'b000;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (fifo_wr && fq[k].size() < 16) begin
                    fq[k].push_back(din);
                    exp_q[k].push_back(din);
                end else if (fifo_rd[k] && fq[k].size() > 0) begin
                    fifo_dout[k] <= fq[k].pop_front();
                end
                fifo_empty[k] <= (fq[k].size() == 0);
                fifo_full[k]  <= (fq[k].size() == 16);
            end
        end
    end

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, k, act, exp);
        end
    endtask

    task automatic monitor(input int k);
        int          c, len, start;
        bit          aborted, busy_ok, rd_ok;
        logic [7:0]  b;
        logic [11:0] bits;
        logic [63:0] wave, ewave, done, edone;
        forever begin
            @(negedge clk);
            if (!rst && frame_done[k] === 1'b1) begin
                checks++; errors++;
                $display("FAIL stray_frame_done[%0d]: got 1 expected 0", k);
            end
            if (!rst && txd[k] === 1'b0) begin
                c = cpb(k);
                len = c * (10 + int'(pen(k)));
                start = cyc;
                if (gap_chk && last_end[k] >= 0)
                    chk("frame_gap", k, 64'(start - last_end[k] - 1), 64'd2);
                b = 8'h00;
                if (exp_q[k].size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_frame[%0d]: got a frame expected none", k);
                end else begin
                    b = exp_q[k].pop_front();
                end
                bits = '1;
                bits[0] = 1'b0;
                for (int i = 0; i < 8; i++) bits[1 + i] = b[i];
                if (pen(k)) bits[9] = (^b) ^ podd(k);
                wave = '0; ewave = '0; done = '0;
                busy_ok = 1'b1; rd_ok = 1'b1; aborted = 1'b0;
                for (int i = 0; i < len && !aborted; i++) begin
                    if (i > 0) @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                    end else begin
                        wave[i]  = txd[k];
                        done[i]  = frame_done[k];
                        ewave[i] = bits[i / c];
                        if (busy[k] !== 1'b1) busy_ok = 1'b0;
                        if (fifo_rd[k] !== 1'b0) rd_ok = 1'b0;
                    end
                end
                if (!aborted) begin
                    edone = 64'd1 << (len - 1);
                    chk("txd_wave", k, wave, ewave);
                    chk("frame_done_pulse", k, done, edone);
                    chk("busy_in_frame", k, 64'(busy_ok), 64'd1);
                    chk("no_rd_in_frame", k, 64'(rd_ok), 64'd1);
                    last_end[k] = cyc;
                    cnt_m[k] = cnt_m[k] + 16'd1;
                    @(negedge clk);
                    if (!rst) begin
                        chk("frame_cnt", k, 64'(frame_cnt[k]), 64'(cnt_m[k]));
                        chk("txd_high_after", k, 64'(txd[k]), 64'd1);
                    end
                end
            end
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_wr = 1'b1;
        din = b;
        @(negedge clk);
        fifo_wr = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int quiet = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy == 3'b000) quiet++;
            else quiet = 0;
            if (quiet >= 4) return;
        end
        checks++; errors++;
        $display("FAIL idle_timeout: busy=%b after %0d cycles, expected 000", busy, budget);
    endtask

    initial begin
        fork
            monitor(0);
            monitor(1);
            monitor(2);
        join_none
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_txd", k, 64'(txd[k]), 64'd1);
            chk("rst_busy", k, 64'(busy[k]), 64'd0);
            chk("rst_frame_done", k, 64'(frame_done[k]), 64'd0);
            chk("rst_fifo_rd", k, 64'(fifo_rd[k]), 64'd0);
            chk("rst_frame_cnt", k, 64'(frame_cnt[k]), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Single frame and IDLE-to-start latency.
        push(8'hA5);
        @(negedge clk);
        en = 1'b1;
        lat = '{default: 0};
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (lat[k] == 0 && txd[k] === 1'b0) lat[k] = i;
        end
        for (int k = 0; k < 3; k++) chk("start_latency", k, 64'(lat[k]), 64'd3);
        wait_idle(200);

        // Back-to-back frames with the two-cycle refill gap.
        en = 1'b0;
        push(8'h00); push(8'hFF); push(8'h3C); push(8'h01);
        for (int k = 0; k < 3; k++) last_end[k] = -1;
        gap_chk = 1'b1;
        en = 1'b1;
        wait_idle(1000);
        gap_chk = 1'b0;
        for (int k = 0; k < 3; k++) chk("burst_drained", k, 64'(fq[k].size()), 64'd0);

        // Write collision while fetching: read held until the writes stop.
        en = 1'b0;
        push(8'h6B);
        en = 1'b1;
        run = '{default: 0};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (fifo_rd[k]) run[k]++;
            fifo_wr = (i < 3);
            din = 8'h11 + 8'(i);
        end
        fifo_wr = 1'b0;
        for (int k = 0; k < 3; k++) chk("collision_rd_cycles", k, 64'(run[k]), 64'd4);
        wait_idle(1000);

        // en dropped mid-frame: finish the frame, leave the rest queued.
        en = 1'b0;
        push(8'h81); push(8'h42);
        en = 1'b1;
        repeat (12) @(negedge clk);
        en = 1'b0;
        wait_idle(300);
        for (int k = 0; k < 3; k++) chk("en_drop_left", k, 64'(fq[k].size()), 64'd1);
        en = 1'b1;
        wait_idle(300);
        for (int k = 0; k < 3; k++) chk("en_resume_drained", k, 64'(fq[k].size()), 64'd0);

        // Asynchronous reset in the middle of DATA.
        en = 1'b0;
        push(8'h55);
        en = 1'b1;
        repeat (12) @(negedge clk);
        #2;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q[k].delete();
            cnt_m[k] = 16'd0;
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("midframe_rst_txd", k, 64'(txd[k]), 64'd1);
            chk("midframe_rst_busy", k, 64'(busy[k]), 64'd0);
            chk("midframe_rst_cnt", k, 64'(frame_cnt[k]), 64'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 3'b000;
        repeat (30) begin
            @(negedge clk);
            seen = seen | busy | fifo_rd;
        end
        chk("no_frame_after_rst", 0, 64'(seen), 64'd0);

        // Random traffic with en toggling and frequent write collisions.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            fifo_wr = ($urandom_range(0, 3) == 0);
            din = 8'($urandom);
            if ($urandom_range(0, 39) == 0) en = ~en;
        end
        fifo_wr = 1'b0;
        en = 1'b1;
        wait_idle(3000);
        for (int k = 0; k < 3; k++) begin
            chk("random_fifo_drained", k, 64'(fq[k].size()), 64'd0);
            chk("random_all_bytes_sent", k, 64'(exp_q[k].size()), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
